mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single AXI4-Lite master (16-bit CPU-side interface) between two requesters: instruction fetch (I) and data memory access (D, LW/SW).
- Arbitrates between them, latches the winner's request and issues a one-cycle transaction start to the master.
- Waits for completion or a timeout, then returns the response and a one-cycle acknowledge to the granted requester.
- Sits between the fetch/MEM pipeline stages and axi4_lite_master; the stage stall logic is driven from the requesters' req-without-ack condition.

Parameters:
- MAX_D_STREAK, 3: consecutive D grants allowed while I is pending before I is forced to win.
- TIMEOUT_CYCLES, 255: cycles to wait in WAIT for m_done before aborting with an error. Must be ≥1 and fit in 8 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request; level, held until i_ack
- i_addr  in  16  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  16  fetch data; valid only when i_ack=1
- d_req  in  1  data request; level, held until d_ack
- d_rw  in  1  1=write (SW), 0=read (LW)
- d_addr  in  16  data address
- d_wdata  in  16  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  16  load data; valid only when d_ack=1
- err  out  1  valid with either ack; 1 = AXI error or timeout
- busy  out  1  high in any state other than IDLE
- m_init  out  1  one-cycle transaction start to the master
- m_rw  out  1  to master rw
- m_addr  out  16  to master cpu_rw_addr_i
- m_wdata  out  16  to master cpu_w_data_i
- m_rdata  in  16  from master cpu_r_data_o
- m_done  in  1  master TXN_DONE pulse
- m_error  in  1  master ERROR; sampled with m_done

Behaviour:
- Reset: synchronous, applied on a clk edge with rst_n=0. State goes to IDLE.
  - All outputs are 0: acks, err, m_init, m_rw, m_addr, m_wdata, i_rdata, d_rdata, busy.
  - Streak and timeout counters clear; the grant register clears.
  - Reset mid-transaction discards the transaction; no ack is issued for it.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: D wins unless streak == MAX_D_STREAK, in which case I wins.
  - On a grant, register m_addr/m_wdata/m_rw and the grant owner (I grant forces m_rw=0, m_wdata=0), then go to ISSUE.
  - Streak: increments (saturating) on a D grant made while i_req=1; clears on any I grant; clears on a D grant made while i_req=0.
- ISSUE: m_init=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - m_done=1: capture m_rdata and err<=m_error, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES, capture rdata=0 and err=1, go to RESP.
  - m_done in the same cycle the counter reaches its limit: m_done wins.
- RESP:
  - Owner's ack=1 for one cycle with its rdata and err valid; the non-owner's ack and rdata stay 0.
  - Go to IDLE. Requests present during RESP are not arbitrated; the requester drops req on the cycle after ack.
- Latency: req sampled in IDLE at cycle N; m_init at N+1; m_done at cycle M ≥ N+2; ack at M+1; next grant at the earliest at M+2.
- m_addr, m_wdata and m_rw stay stable from ISSUE through RESP.
- m_done outside WAIT is ignored.
- rdata outputs return to 0 when ack is low.
- Only one ack is ever asserted at a time.
- Address/data changes on an already-granted requester's inputs are ignored until its ack.
- busy = (state != IDLE).

Test Plan:
- Single read: i_req=1, i_addr=0x0010; m_done with m_rdata=0xA5B4 two cycles after m_init.
  -> m_init one cycle after req, m_addr=0x0010, m_rw=0, i_ack one cycle after m_done with i_rdata=0xA5B4, err=0.
- Write with error: d_req=1, d_rw=1, d_addr=0x0100, d_wdata=0x1234; m_done with m_error=1.
  -> m_rw=1, m_wdata=0x1234, d_ack with err=1, i_ack stays 0.
- Contention and starvation: i_req held 1; d_req re-asserted immediately after each d_ack; MAX_D_STREAK=3.
  -> grant sequence D,D,D,I,D,...; i_ack arrives after exactly three d_acks.
- Timeout: TIMEOUT_CYCLES=4; d_req read; m_done never asserted.
  -> d_ack exactly 4 WAIT cycles after ISSUE, with d_rdata=0x0000 and err=1.
  - Repeat with m_done in the 4th WAIT cycle -> err=0, data captured.
- Reset mid-WAIT: rst_n=0 for one clk during WAIT, then late m_done.
  -> state IDLE, no ack, busy=0; late m_done ignored; a subsequent i_req is served normally.
- Simultaneous request, both idle: i_req=d_req=1 at the same edge, streak=0.
  -> D granted first, I granted after d_ack; m_addr matches each requester's address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one AXI4-Lite master between instruction fetch (I)
// and data access (D). D normally wins a tie; I is forced through after
// MAX_D_STREAK back-to-back D grants made while I was waiting.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch requester
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    // shared status
    output logic        err,
    output logic        busy,
    // AXI4-Lite master side
    output logic        m_init,
    output logic        m_rw,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_done,
    input  logic        m_error
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [7:0] TmoLimit  = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] StreakMax = 8'(MAX_D_STREAK);

    state_e      r_state;
    logic        r_owner_d;
    logic [7:0]  r_streak;
    logic [7:0]  r_tmo_cnt;
    logic        r_m_init;
    logic        r_m_rw;
    logic [15:0] r_m_addr;
    logic [15:0] r_m_wdata;
    logic        r_i_ack;
    logic        r_d_ack;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;
    logic        r_err;

    logic        w_grant_any;
    logic        w_grant_d;
    logic [7:0]  w_tmo_next;
    logic        w_tmo_hit;
    logic        w_finish;
    logic [15:0] w_rsp_data;
    logic        w_rsp_err;

    // Arbitration and response selection; m_done takes priority over the timeout.
    always_comb begin
        w_grant_any = i_req | d_req;
        w_grant_d   = d_req & (~i_req | (r_streak != StreakMax));
        w_tmo_next  = r_tmo_cnt + 8'd1;
        w_tmo_hit   = (w_tmo_next == TmoLimit);
        w_finish    = m_done | w_tmo_hit;
        w_rsp_data  = m_done ? m_rdata : 16'h0000;
        w_rsp_err   = m_done ? m_error : 1'b1;
    end

    // Main FSM with registered outputs; acks, rdata and err are single-cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_owner_d <= 1'b0;
            r_streak  <= 8'd0;
            r_tmo_cnt <= 8'd0;
            r_m_init  <= 1'b0;
            r_m_rw    <= 1'b0;
            r_m_addr  <= 16'h0000;
            r_m_wdata <= 16'h0000;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= 16'h0000;
            r_d_rdata <= 16'h0000;
            r_err     <= 1'b0;
        end else begin
            r_m_init  <= 1'b0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= 16'h0000;
            r_d_rdata <= 16'h0000;
            r_err     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_grant_any) begin
                        r_state  <= StIssue;
                        r_m_init <= 1'b1;
                        if (w_grant_d) begin
                            r_owner_d <= 1'b1;
                            r_m_rw    <= d_rw;
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_wdata;
                            // streak only counts D wins that kept I waiting
                            if (i_req) begin
                                if (r_streak != StreakMax) begin
                                    r_streak <= r_streak + 8'd1;
                                end
                            end else begin
                                r_streak <= 8'd0;
                            end
                        end else begin
                            r_owner_d <= 1'b0;
                            r_m_rw    <= 1'b0;
                            r_m_addr  <= i_addr;
                            r_m_wdata <= 16'h0000;
                            r_streak  <= 8'd0;
                        end
                    end
                end
                StIssue: begin
                    r_tmo_cnt <= 8'd0;
                    r_state   <= StWait;
                end
                StWait: begin
                    if (w_finish) begin
                        r_state <= StResp;
                        r_err   <= w_rsp_err;
                        if (r_owner_d) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= w_rsp_data;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= w_rsp_data;
                        end
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy    = (r_state != StIdle);
    assign m_init  = r_m_init;
    assign m_rw    = r_m_rw;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign err     = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic checked
// against a request-level arbitration model.
module tb_mem_port_arbiter;

    localparam int unsigned MaxStreak = 3;
    localparam int unsigned Tmo       = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_rw;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        err;
    logic        busy;
    logic        m_init;
    logic        m_rw;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_done;
    logic        m_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_D_STREAK  (MaxStreak),
        .TIMEOUT_CYCLES(Tmo)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_ack  (i_ack),
        .i_rdata(i_rdata),
        .d_req  (d_req),
        .d_rw   (d_rw),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_ack  (d_ack),
        .d_rdata(d_rdata),
        .err    (err),
        .busy   (busy),
        .m_init (m_init),
        .m_rw   (m_rw),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_done (m_done),
        .m_error(m_error)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_i_ack"}, i_ack, 1'b0);
        chk1({tag, "_d_ack"}, d_ack, 1'b0);
        chk16({tag, "_i_rdata"}, i_rdata, 16'h0000);
        chk16({tag, "_d_rdata"}, d_rdata, 16'h0000);
        chk1({tag, "_m_init"}, m_init, 1'b0);
    endtask

    // From an IDLE negedge with requests driven: grant, issue, wait, respond.
    // Ends at the negedge of the acknowledge cycle.
    task automatic txn(input logic own_d, input logic [15:0] ea, input logic erw,
                       input logic [15:0] ewd, input int unsigned n_idle,
                       input logic use_done, input logic [15:0] rd, input logic er);
        logic        timeout;
        logic [15:0] xrd;
        logic        xerr;
        int unsigned lc;
        timeout = !use_done || (n_idle >= Tmo);
        xrd     = timeout ? 16'h0000 : rd;
        xerr    = timeout ? 1'b1 : er;
        lc      = timeout ? Tmo : n_idle;
        tick();
        chk1("issue_m_init", m_init, 1'b1);
        chk16("issue_m_addr", m_addr, ea);
        chk1("issue_m_rw", m_rw, erw);
        chk16("issue_m_wdata", m_wdata, ewd);
        chk1("issue_busy", busy, 1'b1);
        tick();
        chk1("wait_m_init_low", m_init, 1'b0);
        for (int k = 0; k < int'(lc); k++) begin
            chk1("wait_no_ack", i_ack | d_ack, 1'b0);
            // granted requester's inputs must be ignored until its ack
            if (own_d) begin
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
                d_rw    = 1'($urandom);
            end else begin
                i_addr = 16'($urandom);
            end
            tick();
        end
        if (!timeout) begin
            chk1("done_no_ack", i_ack | d_ack, 1'b0);
            m_done  = 1'b1;
            m_rdata = rd;
            m_error = er;
            tick();
            m_done  = 1'b0;
            m_rdata = 16'($urandom);
            m_error = 1'($urandom);
        end
        chk1("resp_i_ack", i_ack, !own_d);
        chk1("resp_d_ack", d_ack, own_d);
        chk16("resp_i_rdata", i_rdata, own_d ? 16'h0000 : xrd);
        chk16("resp_d_rdata", d_rdata, own_d ? xrd : 16'h0000);
        chk1("resp_err", err, xerr);
        chk16("resp_m_addr_stable", m_addr, ea);
        chk1("resp_m_rw_stable", m_rw, erw);
        chk16("resp_m_wdata_stable", m_wdata, ewd);
    endtask

    task automatic to_idle(input string tag);
        tick();
        chk_idle(tag);
    endtask

    initial begin
        logic        pend_i;
        logic        pend_d;
        logic [15:0] i_a;
        logic [15:0] d_a;
        logic [15:0] d_w;
        logic        d_r;
        int unsigned streak;
        logic        own_d;
        logic        i_seen;
        int          dacks;
        logic [15:0] d_cur;

        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = 16'h0000;
        d_req   = 1'b0;
        d_rw    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
        m_rdata = 16'h0000;
        m_done  = 1'b0;
        m_error = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk1("reset_err", err, 1'b0);
        chk1("reset_m_rw", m_rw, 1'b0);
        chk16("reset_m_addr", m_addr, 16'h0000);
        chk16("reset_m_wdata", m_wdata, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset");

        // single read: done two cycles after m_init
        i_req  = 1'b1;
        i_addr = 16'h0010;
        txn(1'b0, 16'h0010, 1'b0, 16'h0000, 1, 1'b1, 16'hA5B4, 1'b0);
        i_req = 1'b0;
        to_idle("single_read");

        // write with error response
        d_req   = 1'b1;
        d_rw    = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 16'h1234;
        txn(1'b1, 16'h0100, 1'b1, 16'h1234, 0, 1'b1, 16'h0000, 1'b1);
        d_req = 1'b0;
        to_idle("write_err");

        // contention: I held, D re-requests after every ack
        i_req  = 1'b1;
        i_addr = 16'h0200;
        i_seen = 1'b0;
        dacks  = 0;
        for (int j = 0; j < 5; j++) begin
            own_d = (j != 3);
            if (own_d) begin
                d_cur   = 16'h0300 + 16'(j);
                d_req   = 1'b1;
                d_rw    = 1'b0;
                d_addr  = d_cur;
                d_wdata = 16'h00C0 + 16'(j);
                txn(1'b1, d_cur, 1'b0, 16'h00C0 + 16'(j), $urandom % Tmo, 1'b1,
                    16'($urandom), 1'b0);
            end else begin
                txn(1'b0, 16'h0200, 1'b0, 16'h0000, $urandom % Tmo, 1'b1,
                    16'($urandom), 1'b0);
                i_addr = 16'h0204;
            end
            if (d_ack) dacks++;
            if (i_ack && !i_seen) begin
                i_seen = 1'b1;
                chk16("starve_dacks_before_i", 16'(dacks), 16'd3);
            end
            to_idle("contention");
        end
        chk1("starve_i_served", i_seen, 1'b1);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk_idle("contention_end");

        // timeout, then done landing in the last allowed WAIT cycle
        d_req   = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 16'h0400;
        d_wdata = 16'h0044;
        txn(1'b1, 16'h0400, 1'b0, 16'h0044, Tmo, 1'b0, 16'h0000, 1'b0);
        d_addr  = 16'h0404;
        d_rw    = 1'b0;
        d_wdata = 16'h0045;
        to_idle("timeout");
        txn(1'b1, 16'h0404, 1'b0, 16'h0045, Tmo - 1, 1'b1, 16'h5A5A, 1'b0);
        d_req = 1'b0;
        to_idle("late_done_ok");

        // reset during WAIT discards the transaction
        i_req  = 1'b1;
        i_addr = 16'h0500;
        tick();
        tick();
        chk1("rst_mid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        i_req = 1'b0;
        tick();
        chk_idle("rst_mid");
        chk16("rst_mid_m_addr", m_addr, 16'h0000);
        rst_n   = 1'b1;
        m_done  = 1'b1;
        m_rdata = 16'hDEAD;
        tick();
        m_done = 1'b0;
        chk_idle("stray_done");
        tick();
        chk_idle("stray_done_2");
        i_req  = 1'b1;
        i_addr = 16'h0510;
        txn(1'b0, 16'h0510, 1'b0, 16'h0000, 0, 1'b1, 16'h1111, 1'b0);
        i_req = 1'b0;
        to_idle("after_rst");

        // simultaneous requests with streak at zero
        i_req   = 1'b1;
        i_addr  = 16'h0600;
        d_req   = 1'b1;
        d_rw    = 1'b1;
        d_addr  = 16'h0700;
        d_wdata = 16'h7777;
        txn(1'b1, 16'h0700, 1'b1, 16'h7777, 1, 1'b1, 16'h2222, 1'b0);
        d_req = 1'b0;
        to_idle("simul_d");
        txn(1'b0, 16'h0600, 1'b0, 16'h0000, 2, 1'b1, 16'h3333, 1'b0);
        i_req = 1'b0;
        to_idle("simul_i");

        // randomized traffic against the arbitration model
        pend_i = 1'b0;
        pend_d = 1'b0;
        i_a    = 16'h0000;
        d_a    = 16'h0000;
        d_w    = 16'h0000;
        d_r    = 1'b0;
        streak = 0;
        for (int n = 0; n < 40; n++) begin
            if (!pend_i && !pend_d) begin
                if ($urandom % 2 == 0) begin
                    pend_i = 1'b1;
                    i_a    = 16'($urandom);
                end else begin
                    pend_d = 1'b1;
                    d_a    = 16'($urandom);
                    d_w    = 16'($urandom);
                    d_r    = 1'($urandom);
                end
            end
            i_req   = pend_i;
            i_addr  = i_a;
            d_req   = pend_d;
            d_addr  = d_a;
            d_wdata = d_w;
            d_rw    = d_r;
            own_d = pend_d && (!pend_i || streak < MaxStreak);
            if (own_d && pend_i) streak = (streak < MaxStreak) ? streak + 1 : MaxStreak;
            else streak = 0;
            if ($urandom % 4 == 0) begin
                txn(own_d, own_d ? d_a : i_a, own_d ? d_r : 1'b0, own_d ? d_w : 16'h0000,
                    Tmo, 1'b0, 16'h0000, 1'b0);
            end else begin
                txn(own_d, own_d ? d_a : i_a, own_d ? d_r : 1'b0, own_d ? d_w : 16'h0000,
                    $urandom % Tmo, 1'b1, 16'($urandom), 1'($urandom));
            end
            if (own_d) pend_d = 1'b0;
            else pend_i = 1'b0;
            if (!pend_i && ($urandom % 2 == 0)) begin
                pend_i = 1'b1;
                i_a    = 16'($urandom);
            end
            if (!pend_d && ($urandom % 2 == 0)) begin
                pend_d = 1'b1;
                d_a    = 16'($urandom);
                d_w    = 16'($urandom);
                d_r    = 1'($urandom);
            end
            i_req   = pend_i;
            i_addr  = i_a;
            d_req   = pend_d;
            d_addr  = d_a;
            d_wdata = d_w;
            d_rw    = d_r;
            to_idle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
